// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and future schedulers.
package fifo_pkg;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Widest request vector the rotating-priority helper handles.
    localparam int unsigned RR_MAX_N = 8;

    // One-hot of the first set bit in req[0 +: n], searching from start upward with wrap.
    function automatic logic [RR_MAX_N-1:0] rr_first(
        input logic [RR_MAX_N-1:0] req,
        input int unsigned         start,
        input int unsigned         n
    );
        logic [RR_MAX_N-1:0] onehot;
        logic                found;
        int unsigned         idx;
        onehot = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < RR_MAX_N; i++) begin
            if (i < n) begin
                idx = start + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && req[idx[2:0]]) begin
                    onehot[idx[2:0]] = 1'b1;
                    found            = 1'b1;
                end
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid request at or after a start pointer.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [RR_MAX_N-1:0] w_reqExt;
    logic [RR_MAX_N-1:0] w_onehot;

    // Rotate-search the request vector and encode the winner as one-hot plus index.
    always_comb begin
        w_reqExt             = '0;
        w_reqExt[N_REQ-1:0]  = i_req;
        w_onehot             = rr_first(w_reqExt, {{(32-IDX_W){1'b0}}, i_start}, N_REQ);
        o_grant              = w_onehot[N_REQ-1:0];
        o_idx                = '0;
        for (int i = 0; i < int'(RR_MAX_N); i++) begin
            if (w_onehot[i]) begin
                o_idx = IDX_W'(i);
            end
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ valid/ready producers.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*WIDTH-1:0]     req_data_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic                       fifo_wr_dv_o,
    output logic [WIDTH-1:0]           fifo_wr_data_o,
    input  logic                       fifo_full_i,
    output logic [N_REQ-1:0]           grant_o,
    output logic [$clog2(N_REQ)-1:0]   src_id_o
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    state_e             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_wrDv;
    logic [WIDTH-1:0]   r_wrData;
    logic [IDX_W-1:0]   r_srcId;

    logic [N_REQ-1:0]   w_pickGrant;
    logic [IDX_W-1:0]   w_pickIdx;
    logic               w_pickAny;
    logic               w_burst;
    logic               w_gValid;
    logic               w_beat;
    logic               w_release;
    logic [IDX_W-1:0]   w_nextPtr;
    logic [WIDTH-1:0]   w_wordSel;
    logic [N_REQ-1:0]   w_ready;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rrPick (
        .i_req   (req_valid_i),
        .i_start (r_ptr),
        .o_grant (w_pickGrant),
        .o_idx   (w_pickIdx),
        .o_any   (w_pickAny)
    );

    // Beat, release and ready decode; a full FIFO freezes the burst, including idle detection.
    always_comb begin
        w_burst   = (r_state == ST_BURST);
        w_gValid  = req_valid_i[r_idx];
        w_beat    = w_burst && w_gValid && !fifo_full_i;
        w_release = (w_beat && (r_cnt == CNT_W'(MAX_BURST - 1))) ||
                    (w_burst && !w_gValid && !fifo_full_i);
        w_nextPtr = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
        w_wordSel = req_data_i[r_idx*WIDTH +: WIDTH];
        w_ready   = '0;
        if (w_burst && !fifo_full_i) begin
            w_ready[r_idx] = 1'b1;
        end
    end

    // Grant state machine: pick in ARB, count beats in BURST, hand priority to the next index on release.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_ARB;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_ARB) begin
            if (w_pickAny) begin
                r_state <= ST_BURST;
                r_grant <= w_pickGrant;
                r_idx   <= w_pickIdx;
                r_cnt   <= '0;
            end
        end else begin
            if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_release) begin
                r_state <= ST_ARB;
                r_grant <= '0;
                r_ptr   <= w_nextPtr;
            end
        end
    end

    // Registered FIFO write port; data and source hold between beats.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wrDv   <= 1'b0;
            r_wrData <= '0;
            r_srcId  <= '0;
        end else begin
            r_wrDv <= w_beat;
            if (w_beat) begin
                r_wrData <= w_wordSel;
                r_srcId  <= r_idx;
            end
        end
    end

    assign req_ready_o    = w_ready;
    assign grant_o        = r_grant;
    assign fifo_wr_dv_o   = r_wrDv;
    assign fifo_wr_data_o = r_wrData;
    assign src_id_o       = r_srcId;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk_i;
    logic           rstn_i;
    logic [N-1:0]   reqValid;
    logic [N*W-1:0] reqData;
    logic [N-1:0]   reqReady;
    logic           fifoWrDv;
    logic [W-1:0]   fifoWrData;
    logic           fifoFull;
    logic [N-1:0]   grant;
    logic [1:0]     srcId;

    logic           fullDrv;
    logic           useFifo;
    logic           fifoClr;
    int             fifoCnt;
    int             overflowCnt;

    logic [4:0]     seq [N];
    logic [N-1:0]   acc;
    int             passCnt;
    int             checkCnt;
    int             writeCnt;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] data;
    } exp_t;
    exp_t expQ[$];

    typedef struct {
        bit         rst;
        logic [3:0] valid;
        bit         full;
        logic [3:0] grant;
        logic [3:0] ready;
        bit         dv;
        logic [1:0] src;
    } vec_t;
    vec_t vecs[$];

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .req_valid_i    (reqValid),
        .req_data_i     (reqData),
        .req_ready_o    (reqReady),
        .fifo_wr_dv_o   (fifoWrDv),
        .fifo_wr_data_o (fifoWrData),
        .fifo_full_i    (fifoFull),
        .grant_o        (grant),
        .src_id_o       (srcId)
    );

    // Free-running clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Each producer presents {its index, running sequence number}.
    always_comb begin
        reqData = '0;
        for (int k = 0; k < N; k++) begin
            reqData[k*W +: W] = {3'(k), seq[k]};
        end
    end

    // 16-deep FIFO occupancy model; full already counts the write on the port this cycle.
    always @(posedge clk_i) begin
        if (fifoClr) begin
            fifoCnt     <= 0;
            overflowCnt <= 0;
        end else if (fifoWrDv) begin
            if (fifoCnt >= 16) overflowCnt <= overflowCnt + 1;
            else               fifoCnt     <= fifoCnt + 1;
        end
    end

    assign fifoFull = useFifo ? ((fifoCnt + int'(fifoWrDv)) >= 16) : fullDrv;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checkCnt++;
        if (got === want) passCnt++;
        else $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic full);
        reqValid = valid;
        fullDrv  = full;
    endtask

    task automatic resyncQueue();
        exp_t e;
        expQ.delete();
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 32; j++) begin
                e.src  = 2'(k);
                e.data = {3'(k), seq[k] + 5'(j)};
                expQ.push_back(e);
            end
        end
    endtask

    task automatic monitorWrites();
        int  hit;
        hit = -1;
        if (fifoWrDv) begin
            writeCnt++;
            for (int i = 0; i < expQ.size(); i++) begin
                if (hit < 0 && expQ[i].src == srcId) hit = i;
            end
            if (hit < 0) begin
                checkCnt++;
                $display("[TB] FAIL sb_src: got src %0d, want a queued source", srcId);
            end else begin
                checkOutput("sb_data", 32'(fifoWrData), 32'(expQ[hit].data));
                expQ.delete(hit);
            end
        end
    endtask

    task automatic waitNeg();
        @(negedge clk_i);
        monitorWrites();
        acc = reqValid & reqReady;
    endtask

    task automatic advance();
        @(posedge clk_i);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) seq[k] = seq[k] + 5'd1;
        end
    endtask

    task automatic doReset();
        rstn_i = 1'b0;
        #1;
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_ready", 32'(reqReady), 32'h0);
        checkOutput("rst_dv", 32'(fifoWrDv), 32'h0);
        checkOutput("rst_data", 32'(fifoWrData), 32'h0);
        checkOutput("rst_src", 32'(srcId), 32'h0);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        resyncQueue();
    endtask

    task automatic addRow(input bit r, input logic [3:0] v, input bit f, input logic [3:0] g,
                          input logic [3:0] rd, input bit d, input logic [1:0] s);
        vec_t x;
        x.rst = r; x.valid = v; x.full = f; x.grant = g; x.ready = rd; x.dv = d; x.src = s;
        vecs.push_back(x);
    endtask

    initial begin
        int          srcLog[$];
        logic [3:0]  grantLog[$];
        logic [3:0]  prevGrant;
        int          strobeAtFull;

        passCnt  = 0;
        checkCnt = 0;
        writeCnt = 0;
        rstn_i   = 1'b0;
        useFifo  = 1'b0;
        fifoClr  = 1'b1;
        acc      = '0;
        for (int k = 0; k < N; k++) seq[k] = '0;
        applyStimulus(4'h0, 1'b0);

        // Single requester 2: four back-to-back writes, one ARB gap, regrant, then idle release.
        addRow(1, 4'h4, 0, 4'h0, 4'h0, 0, 0);
        addRow(0, 4'h4, 0, 4'h4, 4'h4, 0, 0);
        addRow(0, 4'h4, 0, 4'h4, 4'h4, 1, 2);
        addRow(0, 4'h4, 0, 4'h4, 4'h4, 1, 2);
        addRow(0, 4'h4, 0, 4'h4, 4'h4, 1, 2);
        addRow(0, 4'h4, 0, 4'h0, 4'h0, 1, 2);
        addRow(0, 4'h4, 0, 4'h4, 4'h4, 0, 0);
        addRow(0, 4'h4, 0, 4'h4, 4'h4, 1, 2);
        addRow(0, 4'h0, 0, 4'h4, 4'h4, 1, 2);
        addRow(0, 4'h0, 0, 4'h0, 4'h0, 0, 0);
        // Full stall on requester 1, valid dipping while full, burst still totals four beats.
        addRow(1, 4'h2, 0, 4'h0, 4'h0, 0, 0);
        addRow(0, 4'h2, 0, 4'h2, 4'h2, 0, 0);
        addRow(0, 4'h2, 0, 4'h2, 4'h2, 1, 1);
        addRow(0, 4'h2, 1, 4'h2, 4'h0, 1, 1);
        addRow(0, 4'h2, 1, 4'h2, 4'h0, 0, 0);
        addRow(0, 4'h0, 1, 4'h2, 4'h0, 0, 0);
        addRow(0, 4'h2, 1, 4'h2, 4'h0, 0, 0);
        addRow(0, 4'h2, 1, 4'h2, 4'h0, 0, 0);
        addRow(0, 4'h2, 0, 4'h2, 4'h2, 0, 0);
        addRow(0, 4'h2, 0, 4'h2, 4'h2, 1, 1);
        addRow(0, 4'h2, 0, 4'h0, 4'h0, 1, 1);
        addRow(0, 4'h2, 0, 4'h2, 4'h2, 0, 0);
        addRow(0, 4'h0, 0, 4'h2, 4'h2, 1, 1);
        addRow(0, 4'h0, 0, 4'h0, 4'h0, 0, 0);
        // Early release by requester 3 after two beats; pointer wraps to 0.
        addRow(1, 4'h8, 0, 4'h0, 4'h0, 0, 0);
        addRow(0, 4'h8, 0, 4'h8, 4'h8, 0, 0);
        addRow(0, 4'h8, 0, 4'h8, 4'h8, 1, 3);
        addRow(0, 4'h1, 0, 4'h8, 4'h8, 1, 3);
        addRow(0, 4'h1, 0, 4'h0, 4'h0, 0, 0);
        addRow(0, 4'h1, 0, 4'h1, 4'h1, 0, 0);
        addRow(0, 4'h1, 0, 4'h1, 4'h1, 1, 0);
        addRow(0, 4'h0, 0, 4'h1, 4'h1, 1, 0);
        addRow(0, 4'h0, 0, 4'h0, 4'h0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) doReset();
            applyStimulus(vecs[i].valid, vecs[i].full);
            waitNeg();
            checkOutput($sformatf("row%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
            checkOutput($sformatf("row%0d_ready", i), 32'(reqReady), 32'(vecs[i].ready));
            checkOutput($sformatf("row%0d_dv", i), 32'(fifoWrDv), 32'(vecs[i].dv));
            if (vecs[i].dv) begin
                checkOutput($sformatf("row%0d_src", i), 32'(srcId), 32'(vecs[i].src));
            end
            advance();
        end

        // All four requesters streaming: grant order 0,1,2,3,0 and four writes per grant.
        doReset();
        applyStimulus(4'hF, 1'b0);
        prevGrant = '0;
        for (int c = 0; c < 40; c++) begin
            waitNeg();
            if (fifoWrDv && srcLog.size() < 20) srcLog.push_back(int'(srcId));
            if (grant != 4'h0 && prevGrant == 4'h0 && grantLog.size() < 5) grantLog.push_back(grant);
            prevGrant = grant;
            advance();
        end
        checkOutput("rr_nwrites", 32'(srcLog.size()), 32'd20);
        for (int i = 0; i < srcLog.size(); i++) begin
            checkOutput($sformatf("rr_src%0d", i), 32'(srcLog[i]), 32'((i / MB) % N));
        end
        checkOutput("rr_ngrants", 32'(grantLog.size()), 32'd5);
        for (int i = 0; i < grantLog.size(); i++) begin
            checkOutput($sformatf("rr_grant%0d", i), 32'(grantLog[i]), 32'(4'h1 << (i % N)));
        end

        // Real 16-deep FIFO with no reads: exactly sixteen writes, none while full.
        doReset();
        useFifo      = 1'b1;
        fifoClr      = 1'b0;
        writeCnt     = 0;
        strobeAtFull = 0;
        applyStimulus(4'hF, 1'b0);
        for (int c = 0; c < 60; c++) begin
            waitNeg();
            if (fifoWrDv && fifoCnt >= 16) strobeAtFull++;
            advance();
        end
        checkOutput("fifo_writes", 32'(writeCnt), 32'd16);
        checkOutput("fifo_count", 32'(fifoCnt), 32'd16);
        checkOutput("fifo_overflow", 32'(overflowCnt), 32'd0);
        checkOutput("fifo_strobe_at_full", 32'(strobeAtFull), 32'd0);
        checkOutput("fifo_ready_blocked", 32'(reqReady), 32'h0);
        checkOutput("fifo_grant_held", 32'(grant != 4'h0), 32'd1);
        useFifo = 1'b0;
        fifoClr = 1'b1;

        // Reset on the third beat of requester 2's second burst; pointer must restart at 0.
        doReset();
        applyStimulus(4'h4, 1'b0);
        for (int c = 0; c < 8; c++) begin
            waitNeg();
            advance();
        end
        checkOutput("pre_rst_grant", 32'(grant), 32'h4);
        checkOutput("pre_rst_ready", 32'(reqReady), 32'h4);
        checkOutput("pre_rst_dv", 32'(fifoWrDv), 32'h1);
        #1;
        rstn_i = 1'b0;
        #1;
        checkOutput("async_grant", 32'(grant), 32'h0);
        checkOutput("async_ready", 32'(reqReady), 32'h0);
        checkOutput("async_dv", 32'(fifoWrDv), 32'h0);
        checkOutput("async_data", 32'(fifoWrData), 32'h0);
        checkOutput("async_src", 32'(srcId), 32'h0);
        applyStimulus(4'hC, 1'b0);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        resyncQueue();
        waitNeg();
        checkOutput("post_rst_arb", 32'(grant), 32'h0);
        advance();
        waitNeg();
        checkOutput("post_rst_grant", 32'(grant), 32'h4);
        advance();
        applyStimulus(4'h0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            waitNeg();
            advance();
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
